// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the 4 x 16 register file: round-robin between ALU (A) and load (B)
// onto the single write port, plus a per-register pending scoreboard for decode hazard stalls.

module rf_wb_sb_bit (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic pend
);
  // A same-edge set beats clear: the set belongs to a newer writer still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    pend <= 1'b0;
    else if (set) pend <= 1'b1;
    else if (clr) pend <= 1'b0;
  end
endmodule

module rf_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int NREG   = 4,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [AW-1:0]     a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [AW-1:0]     b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_reg,
  output logic [AW-1:0]     wreg,
  output logic [DATA_W-1:0] wdata,
  output logic              write_en,
  output logic [NREG-1:0]   pending
);

  typedef enum logic {GA = 1'b0, GB = 1'b1} last_t;

  last_t last;
  logic  grant_a, grant_b;

  // Contention goes to whichever source was not granted most recently.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (a_valid && b_valid) begin
        grant_a = (last == GB);
        grant_b = (last == GA);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last     <= GB;
      write_en <= 1'b0;
      wreg     <= '0;
      wdata    <= '0;
    end else if (grant_a) begin
      last     <= GA;
      write_en <= 1'b1;
      wreg     <= a_reg;
      wdata    <= a_data;
    end else if (grant_b) begin
      last     <= GB;
      write_en <= 1'b1;
      wreg     <= b_reg;
      wdata    <= b_data;
    end else begin
      write_en <= 1'b0;
    end
  end

  // One pending bit per register; cleared by the write committing this cycle.
  logic [NREG-1:0] sb_set, sb_clr;

  for (genvar r = 0; r < NREG; r++) begin : g_sb
    assign sb_set[r] = issue_en && (issue_reg == AW'(r));
    assign sb_clr[r] = write_en && (wreg == AW'(r));
    rf_wb_sb_bit u_sb (
      .clk   (clk),
      .reset (reset),
      .set   (sb_set[r]),
      .clr   (sb_clr[r]),
      .pend  (pending[r])
    );
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed table-driven bench for rf_wb_arbiter plus a hand-written async reset sequence.

module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, a_ready, b_ready, issue_en, write_en;
  logic [1:0]  a_reg, b_reg, issue_reg, wreg;
  logic [15:0] a_data, b_data, wdata;
  logic [3:0]  pending;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_W(16), .NREG(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .issue_en(issue_en), .issue_reg(issue_reg),
    .wreg(wreg), .wdata(wdata), .write_en(write_en), .pending(pending)
  );

  typedef struct {
    logic av; logic [1:0] ar; logic [15:0] ad;
    logic bv; logic [1:0] br; logic [15:0] bd;
    logic ie; logic [1:0] ir;
    logic ea; logic eb; logic ewe; logic [1:0] ewr; logic [15:0] ewd; logic [3:0] ep;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [1:0] ar, logic [15:0] ad,
                              logic bv, logic [1:0] br, logic [15:0] bd,
                              logic ie, logic [1:0] ir,
                              logic ea, logic eb, logic ewe, logic [1:0] ewr,
                              logic [15:0] ewd, logic [3:0] ep);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.ie = ie; v.ir = ir; v.ea = ea; v.eb = eb; v.ewe = ewe; v.ewr = ewr;
    v.ewd = ewd; v.ep = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(logic av, logic [1:0] ar, logic [15:0] ad,
                       logic bv, logic [1:0] br, logic [15:0] bd,
                       logic ie, logic [1:0] ir);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    issue_en = ie; issue_reg = ir;
  endtask

  initial begin
    // Row i: inputs held during cycle i; expectations are what is visible in cycle i.
    //                 av ar ad       bv br bd       ie ir   ea eb we wr wd       pend
    vecs.push_back(mk(1, 1, 16'd15,  1, 2, 16'd20, 0, 0,  1, 0, 0, 0, 16'd0,  4'b0000)); // 0 first contention
    vecs.push_back(mk(0, 0, 16'd0,   1, 2, 16'd20, 0, 0,  0, 1, 1, 1, 16'd15, 4'b0000));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  0, 0,  0, 0, 1, 2, 16'd20, 4'b0000));
    vecs.push_back(mk(0, 0, 16'd0,   1, 3, 16'd10, 0, 0,  0, 1, 0, 2, 16'd20, 4'b0000)); // 3 single B
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  0, 0,  0, 0, 1, 3, 16'd10, 4'b0000));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  0, 0,  0, 0, 0, 3, 16'd10, 4'b0000));
    vecs.push_back(mk(1, 0, 16'hA0,  1, 3, 16'hB0, 0, 0,  1, 0, 0, 3, 16'd10, 4'b0000)); // 6 round-robin
    vecs.push_back(mk(1, 0, 16'hA1,  1, 3, 16'hB0, 0, 0,  0, 1, 1, 0, 16'hA0, 4'b0000));
    vecs.push_back(mk(1, 0, 16'hA1,  1, 3, 16'hB1, 0, 0,  1, 0, 1, 3, 16'hB0, 4'b0000));
    vecs.push_back(mk(1, 0, 16'hA2,  1, 3, 16'hB1, 0, 0,  0, 1, 1, 0, 16'hA1, 4'b0000));
    vecs.push_back(mk(1, 0, 16'hA2,  1, 3, 16'hB2, 0, 0,  1, 0, 1, 3, 16'hB1, 4'b0000));
    vecs.push_back(mk(1, 0, 16'hA3,  1, 3, 16'hB2, 0, 0,  0, 1, 1, 0, 16'hA2, 4'b0000));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  0, 0,  0, 0, 1, 3, 16'hB2, 4'b0000));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  0, 0,  0, 0, 0, 3, 16'hB2, 4'b0000));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  1, 1,  0, 0, 0, 3, 16'hB2, 4'b0000)); // 14 scoreboard
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  0, 0,  0, 0, 0, 3, 16'hB2, 4'b0010));
    vecs.push_back(mk(1, 1, 16'h55,  0, 0, 16'd0,  0, 0,  1, 0, 0, 3, 16'hB2, 4'b0010));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  0, 0,  0, 0, 1, 1, 16'h55, 4'b0010));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  0, 0,  0, 0, 0, 1, 16'h55, 4'b0000));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  1, 2,  0, 0, 0, 1, 16'h55, 4'b0000)); // 19 collision
    vecs.push_back(mk(1, 1, 16'h66,  0, 0, 16'd0,  0, 0,  1, 0, 0, 1, 16'h55, 4'b0100));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  1, 1,  0, 0, 1, 1, 16'h66, 4'b0100));
    vecs.push_back(mk(0, 0, 16'd0,   1, 2, 16'h77, 0, 0,  0, 1, 0, 1, 16'h66, 4'b0110));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  1, 3,  0, 0, 1, 2, 16'h77, 4'b0110));
    vecs.push_back(mk(0, 0, 16'd0,   0, 0, 16'd0,  0, 0,  0, 0, 0, 2, 16'h77, 4'b1010));

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #8;
    chk("rst_write_en", {31'd0, write_en}, 32'd0);
    chk("rst_wreg",     {30'd0, wreg},     32'd0);
    chk("rst_wdata",    {16'd0, wdata},    32'd0);
    chk("rst_pending",  {28'd0, pending},  32'd0);
    #4 reset = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd,
               vecs[i].ie, vecs[i].ir);
      #4;
      chk($sformatf("v%0d_a_ready", i),  {31'd0, a_ready},  {31'd0, vecs[i].ea});
      chk($sformatf("v%0d_b_ready", i),  {31'd0, b_ready},  {31'd0, vecs[i].eb});
      chk($sformatf("v%0d_write_en", i), {31'd0, write_en}, {31'd0, vecs[i].ewe});
      chk($sformatf("v%0d_wreg", i),     {30'd0, wreg},     {30'd0, vecs[i].ewr});
      chk($sformatf("v%0d_wdata", i),    {16'd0, wdata},    {16'd0, vecs[i].ewd});
      chk($sformatf("v%0d_pending", i),  {28'd0, pending},  {28'd0, vecs[i].ep});
    end

    // Async reset mid-burst: A wins first (last=GB), leaving last=GA before the pulse.
    @(posedge clk);
    #1 drive(1, 2, 16'h1234, 1, 1, 16'h4321, 0, 0);
    #4 chk("mb_a_ready", {31'd0, a_ready}, 32'd1);
    @(posedge clk);
    #1 drive(0, 0, 0, 1, 1, 16'h4321, 0, 0);
    chk("mb_write_en", {31'd0, write_en}, 32'd1);
    chk("mb_wdata",    {16'd0, wdata},    32'h1234);
    chk("mb_pending",  {28'd0, pending},  32'hA);
    #2 reset = 1'b1;
    a_valid = 1'b1;
    #1;
    chk("ar_write_en", {31'd0, write_en}, 32'd0);
    chk("ar_wreg",     {30'd0, wreg},     32'd0);
    chk("ar_wdata",    {16'd0, wdata},    32'd0);
    chk("ar_pending",  {28'd0, pending},  32'd0);
    chk("ar_a_ready",  {31'd0, a_ready},  32'd0);
    chk("ar_b_ready",  {31'd0, b_ready},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 3, 16'hAAAA, 1, 1, 16'h4321, 0, 0);
    #1;
    chk("post_a_ready", {31'd0, a_ready}, 32'd1);
    chk("post_b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk);
    #1 drive(0, 0, 0, 1, 1, 16'h4321, 0, 0);
    chk("post_write_en", {31'd0, write_en}, 32'd1);
    chk("post_wreg",     {30'd0, wreg},     32'd3);
    chk("post_wdata",    {16'd0, wdata},    32'hAAAA);
    chk("post_b_ready",  {31'd0, b_ready},  32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 4 x 16-bit `Register` file. It shares the file's single write port (`wreg`, `wdata`, `write_en`) between two write-back sources, A (ALU) and B (load unit), using valid/ready handshakes and round-robin priority. It also keeps a per-register pending scoreboard that decode uses to stall on read-after-write hazards. It sits between the execute/memory stages and the `Register` instance, and is the only driver of the register file's write port.

## Interface
Parameters:
- DATA_W, 16, data width of a register.
- NREG, 4, number of registers; address width AW = clog2(NREG) = 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  source A has a write-back pending.
- a_reg  in  AW  source A destination register.
- a_data  in  DATA_W  source A write data.
- a_ready  out  1  source A request accepted this cycle (combinational).
- b_valid / b_reg / b_data / b_ready  same roles for source B.
- issue_en  in  1  decode issued an instruction that will write `issue_reg`.
- issue_reg  in  AW  destination of the issued instruction.
- wreg  out  AW  to the register file write address.
- wdata  out  DATA_W  to the register file write data.
- write_en  out  1  to the register file write enable.
- pending  out  NREG  bit r = 1 while register r has an outstanding write.

## Operation
- **Priority pointer `last`** is a 1-bit state, values GA and GB.
  - Reset value is GB, so A wins the first contention.
  - `last` updates to the granted source on every grant, and holds when there is no grant.
- **Arbitration** is combinational, at most one grant per cycle.
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant A if `last`=GB, else grant B.
  - Neither valid: no grant.
  - `a_ready` = grant A; `b_ready` = grant B. Ready never asserts without the matching valid.
- **Acceptance** is valid && ready. The granted source's reg and data are registered into the `wreg`/`wdata` output registers, and `write_en` is registered to 1.
- **No grant:** `write_en` registers 0. `wreg`/`wdata` hold their previous values.
- **Source obligation:** a source keeps valid, reg and data stable until it sees ready. The arbiter does not store a denied request.
- **Scoreboard, per register r, each rising edge:**
  - Set: `issue_en` && `issue_reg`==r.
  - Clear: `write_en`==1 && `wreg`==r, i.e. the write is being committed this cycle.
  - Set and clear on the same edge for the same r: set wins, because a newer writer is outstanding.
  - Set and clear on different registers are independent.
- **No ordering checks:** the scoreboard is a single bit per register, not a count. Decode must not issue a second writer to a register that is still pending; the arbiter does not check this.
- **Reset** (asynchronous, any cycle including mid-operation):
  - Outputs: `write_en`=0, `wreg`=0, `wdata`=0, `pending`=0.
  - State: `last`=GB.
  - Any in-flight request is dropped.
  - While reset is high, `a_ready`=`b_ready`=0.

## Timing
- Acceptance in cycle N gives `write_en`=1 with that source's reg/data during cycle N+1. The register file latches at the end of N+1.
- `pending` bit clears at the edge ending N+1, so it reads 0 from cycle N+2.
- `issue_en` in cycle M gives the `pending` bit = 1 from cycle M+1.
- **Back-to-back:** one grant per cycle gives `write_en` high in consecutive cycles.
  - With both sources continuously valid, grants alternate A, B, A, B.
  - Sustained throughput is 1 write per cycle.
- **Same register from both sources on contending cycles:** the later-granted write lands last and its value persists.
- `a_ready`/`b_ready` depend combinationally on valid and `last`, not on `issue_en`.

## Test plan
- **Reset defaults and first contention:** after reset, assert a_valid and b_valid together with a_reg=1, a_data=15, b_reg=2, b_data=20.
  - Cycle 0: a_ready=1, b_ready=0.
  - Cycle 1: write_en=1, wreg=1, wdata=15; b_ready=1.
  - Cycle 2: write_en=1, wreg=2, wdata=20.
  - Cycle 3: write_en=0.
- **Single source:** b_valid alone with b_reg=3, b_data=10 for one cycle.
  - Cycle 0: b_ready=1.
  - Next cycle: write_en=1, wreg=3, wdata=10.
  - Cycle after that: write_en=0 and wdata holds 10.
- **Round-robin under sustained load:** both sources valid for 6 cycles.
  - Grants are A, B, A, B, A, B.
  - write_en stays high for 6 consecutive cycles, starting 1 cycle later.
- **Scoreboard lifecycle:** issue_en with issue_reg=1 in cycle 0; A writes reg 1, accepted in cycle 2.
  - pending=4'b0010 during cycles 1-3.
  - pending=4'b0000 in cycle 4.
- **Set/clear collision:** an A write to reg 1 commits (write_en=1, wreg=1) in the same cycle as issue_en with issue_reg=1.
  - pending[1] stays 1 on the next cycle.
- **Async reset mid-burst:** both sources valid, reset pulsed mid-cycle with no clock edge.
  - write_en, wreg, wdata and pending go to 0 immediately.
  - After reset release, the first contention is granted to A.
